// File: rtl/codificador_pt2262_if.sv
// Parallel side of the PT2262 encoder: code-word inputs, transmit enable and
// the serial/status outputs.
interface codificador_pt2262_if;
  logic [15:0] A;
  logic [3:0]  D;
  logic        te;
  logic        cod_o;
  logic        busy;
  logic        frame_done;

  modport master (output A, D, te, input cod_o, busy, frame_done);
  modport slave  (input A, D, te, output cod_o, busy, frame_done);
endinterface

// File: rtl/codificador_pt2262.sv
// PT2262-compatible encoder: 8 trinary address pins + 4 data bits + sync per
// frame, all timing in units of alpha = CLK_DIV clk cycles.
//
// state | meaning
// IDLE  | line low, waiting for te
// SEND  | burst in progress, frames back to back
module codificador_pt2262 #(
  parameter int CLK_DIV    = 250,
  parameter int MIN_FRAMES = 4
) (
  input  logic clk,
  input  logic reset,
  codificador_pt2262_if.slave bus
);

  localparam int             PW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [3:0]     NFR_MIN  = 4'(MIN_FRAMES);

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state;
  logic [PW-1:0] pre;
  logic [6:0]    alpha;
  logic [3:0]    sym;
  logic [3:0]    nfr;
  logic [23:0]   shadow;
  logic          cod_r;
  logic          busy_r;
  logic          frame_done_r;

  logic [23:0]   load_word;
  logic [1:0]    code;
  logic          half_val;
  logic          level;
  logic          alpha_last;

  // Data bits are widened to trinary '0'/'1' so all 12 symbols share one decoder.
  always_comb begin
    load_word       = '0;
    load_word[15:0] = bus.A;
    for (int j = 0; j < 4; j++)
      load_word[16 + 2*j +: 2] = {2{bus.D[j]}};
  end

  always_comb begin
    code = 2'b00;
    for (int i = 0; i < 12; i++)
      if (sym == 4'(i)) code = shadow[2*i +: 2];
  end

  // 'F' (10 or 01) is a 0-half followed by a 1-half.
  always_comb begin
    half_val = 1'b0;
    if (code == 2'b11)
      half_val = 1'b1;
    else if (code != 2'b00)
      half_val = alpha[4];

    level = 1'b0;
    if (sym == 4'd12)
      level = (alpha < 7'd4);
    else if (half_val)
      level = (alpha[3:0] < 4'd12);
    else
      level = (alpha[3:0] < 4'd4);

    alpha_last = (sym == 4'd12) ? (alpha == 7'd127) : (alpha[4:0] == 5'd31);
  end

  // cod_o lags the counters by one clk, so the counters wrap one cycle before
  // the frame visibly ends; the stop decision is taken in the frame_done cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      pre          <= '0;
      alpha        <= '0;
      sym          <= '0;
      nfr          <= '0;
      shadow       <= '0;
      cod_r        <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      case (state)
        IDLE: begin
          cod_r  <= 1'b0;
          busy_r <= 1'b0;
          if (bus.te) begin
            state  <= SEND;
            pre    <= '0;
            alpha  <= '0;
            sym    <= '0;
            nfr    <= '0;
            shadow <= load_word;
          end
        end
        SEND: begin
          if (frame_done_r && !bus.te && (nfr >= NFR_MIN)) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            cod_r  <= 1'b0;
            pre    <= '0;
            alpha  <= '0;
            sym    <= '0;
            nfr    <= '0;
          end else begin
            busy_r <= 1'b1;
            if (pre == '0)
              cod_r <= level;
            if (pre == PRE_LAST) begin
              pre <= '0;
              if (alpha_last) begin
                alpha <= '0;
                if (sym == 4'd12) begin
                  sym          <= '0;
                  shadow       <= load_word;
                  frame_done_r <= 1'b1;
                  if (nfr < NFR_MIN)
                    nfr <= nfr + 4'd1;
                end else begin
                  sym <= sym + 4'd1;
                end
              end else begin
                alpha <= alpha + 7'd1;
              end
            end else begin
              pre <= pre + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cod_o      = cod_r;
  assign bus.busy       = busy_r;
  assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_codificador_pt2262.sv
// Bench for codificador_pt2262: per-frame expected waveforms are queued by the
// stimulus and compared by an independent monitor on each frame_done.
module tb_codificador_pt2262;

  localparam int CD = 4;
  localparam int MF = 4;
  localparam int FL = 512 * CD;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  codificador_pt2262_if bus();

  codificador_pt2262 #(.CLK_DIV(CD), .MIN_FRAMES(MF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int           n_checks = 0;
  int           n_err    = 0;
  int           frames_seen = 0;
  logic [511:0] scb[$];
  bit           samp[$];
  int           high_log[$];
  logic [15:0]  fa[16];
  logic [3:0]   fd[16];
  logic [511:0] mon_w;
  int           mon_bad;
  int           mon_hi;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: one bit per alpha of a 512-alpha frame, built from symbol rules.
  function automatic logic [511:0] model(input logic [15:0] a, input logic [3:0] d);
    logic [511:0] w;
    int p, tr, hv;
    w = '0;
    p = 0;
    for (int s = 0; s < 12; s++) begin
      if (s < 8) begin
        case (a[2*s +: 2])
          2'b00:   tr = 0;
          2'b11:   tr = 1;
          default: tr = 2;
        endcase
      end else begin
        tr = d[s-8] ? 1 : 0;
      end
      for (int hh = 0; hh < 2; hh++) begin
        hv = (tr == 1) ? 1 : (tr == 0) ? 0 : hh;
        for (int t = 0; t < 16; t++) begin
          w[p] = (t < ((hv != 0) ? 12 : 4));
          p++;
        end
      end
    end
    for (int t = 0; t < 128; t++) begin
      w[p] = (t < 4);
      p++;
    end
    return w;
  endfunction

  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      samp.delete();
    end else if (bus.busy) begin
      samp.push_back(bus.cod_o);
      if (bus.frame_done) begin
        frames_seen++;
        check("frame_len", samp.size(), FL);
        mon_hi = 0;
        foreach (samp[i]) if (samp[i]) mon_hi++;
        if (scb.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL frame_unexpected: got frame %0d expected none queued", frames_seen);
        end else begin
          mon_w   = scb.pop_front();
          mon_bad = 0;
          foreach (samp[i])
            if (i / CD < 512 && samp[i] != mon_w[i / CD]) mon_bad++;
          check("frame_wave_mismatches", mon_bad, 0);
        end
        high_log.push_back(mon_hi);
        samp.delete();
      end
    end else if (bus.frame_done) begin
      n_checks++;
      n_err++;
      $display("FAIL frame_done_idle: got 1 expected 0 at %0t", $time);
    end
  end

  // h = frame (1-based) during which te is dropped; h = 1 means single-cycle pulse.
  task automatic run_burst(input int h);
    int n, busy_cyc, f0, f;
    n = (h > MF) ? h : MF;
    f0 = frames_seen;
    busy_cyc = 0;
    high_log.delete();
    @(negedge clk);
    bus.A  = fa[0];
    bus.D  = fd[0];
    bus.te = 1'b1;
    scb.push_back(model(fa[0], fd[0]));
    for (int m = 0; m <= n*FL + 8; m++) begin
      @(negedge clk);
      if (m == 0) begin
        check("busy_before_alpha0", bus.busy, 0);
        if (h == 1) bus.te = 1'b0;
      end
      if (m == 1) begin
        check("cod_alpha0", bus.cod_o, 1);
        check("busy_alpha0", bus.busy, 1);
      end
      if (bus.busy) busy_cyc++;
      if (h > 1 && m == (h-1)*FL + 1000) bus.te = 1'b0;
      if (m % FL == 1000) begin
        f = m / FL;
        if (f + 1 < n) begin
          bus.A = fa[f+1];
          bus.D = fd[f+1];
          scb.push_back(model(fa[f+1], fd[f+1]));
        end else begin
          bus.A = 16'($urandom);
          bus.D = 4'($urandom);
        end
      end
    end
    check("busy_cycles", busy_cyc, n*FL);
    check("frame_count", frames_seen - f0, n);
    check("scb_drained", scb.size(), 0);
    check("cod_idle", bus.cod_o, 0);
    scb.delete();
  endtask

  task automatic check_high(input int idx, input int exp);
    if (idx < high_log.size())
      check("frame_high_cycles", high_log[idx], exp);
    else
      check("frame_high_present", idx, high_log.size());
  endtask

  initial begin
    reset  = 1'b0;
    bus.te = 1'b1;
    bus.A  = 16'h0000;
    bus.D  = 4'h0;
    repeat (5) @(negedge clk);
    check("rst_cod", bus.cod_o, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_frame_done", bus.frame_done, 0);
    bus.te = 1'b0;
    reset  = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 16; i++) begin fa[i] = 16'h0000; fd[i] = 4'h0; end
    run_burst(1);
    for (int i = 0; i < 4; i++) check_high(i, 400);

    for (int i = 0; i < 16; i++) begin fa[i] = 16'hFFFF; fd[i] = 4'hF; end
    run_burst(1);
    for (int i = 0; i < 4; i++) check_high(i, 292*CD);

    for (int i = 0; i < 16; i++) begin fa[i] = 16'hAAAA; fd[i] = 4'h5; end
    run_burst(1);
    check_high(0, 196*CD);

    for (int i = 0; i < 16; i++) begin fa[i] = 16'($urandom); fd[i] = 4'($urandom); end
    run_burst(7);

    for (int i = 0; i < 16; i++) begin fa[i] = 16'($urandom); fd[i] = 4'($urandom); end
    run_burst(2);

    fa[0] = 16'h0000;
    fd[0] = 4'h0;
    for (int i = 1; i < 16; i++) begin fa[i] = 16'hFFFF; fd[i] = 4'h0; end
    run_burst(1);
    check_high(0, 100*CD);
    check_high(1, 228*CD);

    @(negedge clk);
    bus.A  = 16'hFFFF;
    bus.D  = 4'hF;
    bus.te = 1'b1;
    @(negedge clk);
    bus.te = 1'b0;
    repeat (20) @(negedge clk);
    check("pre_reset_cod", bus.cod_o, 1);
    check("pre_reset_busy", bus.busy, 1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_cod", bus.cod_o, 0);
    check("async_rst_busy", bus.busy, 0);
    check("async_rst_frame_done", bus.frame_done, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (50) @(negedge clk);
    check("post_reset_busy", bus.busy, 0);
    check("post_reset_cod", bus.cod_o, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
